vermicel_sequencer: RTL and testbench

Multi-cycle control FSM for the Vermicel core. It steps the fetch/decode/execute/memory/writeback datapath one instruction at a time and drives the shared memory bus handshake for both instruction fetch and data access. It also arbitrates interrupt, trap and `mret` events at the instruction boundary, and keeps a retired-instruction counter. It sits between the decoder output (`instruction_t`) and the register file, ALU, PC register and bus interface.

---
 rtl/vermicel_sequencer_if.sv | 32 +++
 rtl/vermicel_sequencer.sv | 135 +++++++++++++
 tb/tb_vermicel_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vermicel_sequencer_if.sv
// Decoded-instruction type and the shared memory bus handshake used by the Vermicel sequencer.
// The sequencer is the bus master; the memory/bus interface answers with mem_ready.
package vermicel_pkg;
    typedef struct packed {
        logic is_load;
        logic is_store;
        logic has_rd;
        logic is_mret;
        logic is_trap;
    } instruction_t;
endpackage

interface vermicel_sequencer_if;
    logic mem_valid;
    logic mem_fetch;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_valid,
        output mem_fetch,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_fetch,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/vermicel_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM with irq/trap/mret arbitration.
// Latency: 4 cycles per instruction, 5 with a data access, plus one per bus wait cycle.
// Backpressure: a bus request is held stable until mem_ready; it is never retracted.
module vermicel_sequencer
    import vermicel_pkg::*;
#(
    parameter bit IRQ_ENABLE_AT_RESET = 1'b0,
    parameter int INSTRET_WIDTH       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  instruction_t             instr,
    input  logic                     irq,
    vermicel_sequencer_if.master     bus,
    output logic                     fetch_en,
    output logic                     decode_en,
    output logic                     execute_en,
    output logic                     load_en,
    output logic                     writeback_en,
    output logic                     pc_en,
    output logic                     irq_taken,
    output logic                     trap_taken,
    output logic                     mret_taken,
    output logic [2:0]               state,
    output logic [INSTRET_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    state_t                   state_q;
    logic                     irq_enable;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic                     irq_accept;

    // Interrupt is only taken at an instruction boundary, and a trap always wins.
    assign irq_accept = irq & irq_enable & ~instr.is_trap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            instret_q  <= '0;
            irq_enable <= IRQ_ENABLE_AT_RESET;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    state_q <= (instr.is_load | instr.is_store) ? S_MEMORY : S_WRITEBACK;
                end
                S_MEMORY: begin
                    if (bus.mem_ready) state_q <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    state_q   <= S_FETCH;
                    instret_q <= instret_q + 1'b1;
                    // A taken interrupt masks further interrupts even when it coincides with mret.
                    if (instr.is_trap || irq_accept) begin
                        irq_enable <= 1'b0;
                    end else if (instr.is_mret) begin
                        irq_enable <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    logic mem_valid_c;
    logic mem_fetch_c;
    logic mem_write_c;

    always_comb begin
        mem_valid_c  = 1'b0;
        mem_fetch_c  = 1'b0;
        mem_write_c  = 1'b0;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        load_en      = 1'b0;
        writeback_en = 1'b0;
        pc_en        = 1'b0;
        irq_taken    = 1'b0;
        trap_taken   = 1'b0;
        mret_taken   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_valid_c = 1'b1;
                    mem_fetch_c = 1'b1;
                    fetch_en    = bus.mem_ready;
                end
                S_DECODE: begin
                    decode_en = 1'b1;
                end
                S_EXECUTE: begin
                    execute_en = 1'b1;
                end
                S_MEMORY: begin
                    mem_valid_c = 1'b1;
                    mem_write_c = instr.is_store;
                    load_en     = bus.mem_ready & instr.is_load;
                end
                S_WRITEBACK: begin
                    pc_en        = 1'b1;
                    writeback_en = instr.has_rd & ~instr.is_trap;
                    trap_taken   = instr.is_trap;
                    mret_taken   = ~instr.is_trap & instr.is_mret;
                    irq_taken    = irq_accept;
                end
                default: begin
                    mem_valid_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_valid = mem_valid_c;
    assign bus.mem_fetch = mem_fetch_c;
    assign bus.mem_write = mem_write_c;
    assign state         = reset ? 3'd0 : state_q;
    assign instret       = reset ? '0 : instret_q;

endmodule

// File: tb/tb_vermicel_sequencer.sv
// Directed bench for vermicel_sequencer: instruction sequences with hand-computed per-cycle outputs.
module tb_vermicel_sequencer;
    import vermicel_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    instruction_t instr;
    logic         irq;
    logic         fetch_en, decode_en, execute_en, load_en, writeback_en, pc_en;
    logic         irq_taken, trap_taken, mret_taken;
    logic [2:0]   state;
    logic [31:0]  instret;

    int checks = 0;
    int errors = 0;

    vermicel_sequencer_if bus ();

    vermicel_sequencer #(
        .IRQ_ENABLE_AT_RESET (1'b1),
        .INSTRET_WIDTH       (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .irq          (irq),
        .bus          (bus.master),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .execute_en   (execute_en),
        .load_en      (load_en),
        .writeback_en (writeback_en),
        .pc_en        (pc_en),
        .irq_taken    (irq_taken),
        .trap_taken   (trap_taken),
        .mret_taken   (mret_taken),
        .state        (state),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    // Output vector: {mem_valid, mem_fetch, mem_write, fetch_en, decode_en, execute_en,
    //                 load_en, writeback_en, pc_en, irq_taken, trap_taken, mret_taken}
    logic [11:0] outs;
    assign outs = {bus.mem_valid, bus.mem_fetch, bus.mem_write, fetch_en, decode_en, execute_en,
                   load_en, writeback_en, pc_en, irq_taken, trap_taken, mret_taken};

    localparam logic [11:0] O_IDLE   = 12'h000;
    localparam logic [11:0] O_FWAIT  = 12'hC00;
    localparam logic [11:0] O_FRDY   = 12'hD00;
    localparam logic [11:0] O_DEC    = 12'h080;
    localparam logic [11:0] O_EXE    = 12'h040;
    localparam logic [11:0] O_LWAIT  = 12'h800;
    localparam logic [11:0] O_LRDY   = 12'h820;
    localparam logic [11:0] O_STORE  = 12'hA00;
    localparam logic [11:0] O_WB_RD  = 12'h018;
    localparam logic [11:0] O_WB     = 12'h008;
    localparam logic [11:0] O_WB_IRQ = 12'h01C;
    localparam logic [11:0] O_WB_TRP = 12'h00A;
    localparam logic [11:0] O_WB_MRT = 12'h009;
    localparam logic [11:0] O_WB_MI  = 12'h00D;

    localparam instruction_t I_ADDI  = '{is_load:1'b0, is_store:1'b0, has_rd:1'b1, is_mret:1'b0, is_trap:1'b0};
    localparam instruction_t I_LOAD  = '{is_load:1'b1, is_store:1'b0, has_rd:1'b1, is_mret:1'b0, is_trap:1'b0};
    localparam instruction_t I_STORE = '{is_load:1'b0, is_store:1'b1, has_rd:1'b0, is_mret:1'b0, is_trap:1'b0};
    localparam instruction_t I_MRET  = '{is_load:1'b0, is_store:1'b0, has_rd:1'b0, is_mret:1'b1, is_trap:1'b0};
    localparam instruction_t I_TRAP  = '{is_load:1'b0, is_store:1'b0, has_rd:1'b1, is_mret:1'b0, is_trap:1'b1};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs are already applied; let them settle, check this cycle, then advance one clock.
    task automatic step(input string tag, input logic [2:0] exp_state, input logic [11:0] exp_outs);
        #1;
        check({tag, "_state"}, {29'd0, state}, {29'd0, exp_state});
        check({tag, "_outs"}, {20'd0, outs}, {20'd0, exp_outs});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        instr         = I_ADDI;
        irq           = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("reset", 3'd0, O_IDLE);
        check("reset_instret", instret, 32'd0);

        // Zero-wait addi x3, with one initial fetch wait cycle.
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        step("fetch_wait", 3'd0, O_FWAIT);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("addi_f", 3'd0, O_FRDY);
            step("addi_d", 3'd1, O_DEC);
            step("addi_e", 3'd2, O_EXE);
            step("addi_w", 3'd4, O_WB_RD);
        end
        check("addi_instret", instret, 32'd3);

        // Load with two wait cycles in MEMORY.
        instr = I_LOAD;
        step("ld_f", 3'd0, O_FRDY);
        step("ld_d", 3'd1, O_DEC);
        step("ld_e", 3'd2, O_EXE);
        bus.mem_ready = 1'b0;
        step("ld_m0", 3'd3, O_LWAIT);
        step("ld_m1", 3'd3, O_LWAIT);
        bus.mem_ready = 1'b1;
        step("ld_m2", 3'd3, O_LRDY);
        step("ld_w", 3'd4, O_WB_RD);
        check("ld_instret", instret, 32'd4);

        // Store without rd.
        instr = I_STORE;
        step("st_f", 3'd0, O_FRDY);
        step("st_d", 3'd1, O_DEC);
        step("st_e", 3'd2, O_EXE);
        step("st_m", 3'd3, O_STORE);
        step("st_w", 3'd4, O_WB);
        check("st_instret", instret, 32'd5);

        // irq enabled from reset: taken once, then masked until mret.
        irq   = 1'b1;
        instr = I_ADDI;
        step("irq1_f", 3'd0, O_FRDY);
        step("irq1_d", 3'd1, O_DEC);
        step("irq1_e", 3'd2, O_EXE);
        step("irq1_w", 3'd4, O_WB_IRQ);
        step("irq2_f", 3'd0, O_FRDY);
        step("irq2_d", 3'd1, O_DEC);
        step("irq2_e", 3'd2, O_EXE);
        step("irq2_w", 3'd4, O_WB_RD);
        instr = I_MRET;
        step("mret1_f", 3'd0, O_FRDY);
        step("mret1_d", 3'd1, O_DEC);
        step("mret1_e", 3'd2, O_EXE);
        step("mret1_w", 3'd4, O_WB_MRT);
        instr = I_ADDI;
        step("irq3_f", 3'd0, O_FRDY);
        step("irq3_d", 3'd1, O_DEC);
        step("irq3_e", 3'd2, O_EXE);
        step("irq3_w", 3'd4, O_WB_IRQ);

        // Re-enable, then a trap with irq pending: trap wins and rd is not written.
        irq   = 1'b0;
        instr = I_MRET;
        step("mret2_f", 3'd0, O_FRDY);
        step("mret2_d", 3'd1, O_DEC);
        step("mret2_e", 3'd2, O_EXE);
        step("mret2_w", 3'd4, O_WB_MRT);
        irq   = 1'b1;
        instr = I_TRAP;
        step("trap_f", 3'd0, O_FRDY);
        step("trap_d", 3'd1, O_DEC);
        step("trap_e", 3'd2, O_EXE);
        step("trap_w", 3'd4, O_WB_TRP);
        check("trap_instret", instret, 32'd11);
        instr = I_ADDI;
        step("post_trap_f", 3'd0, O_FRDY);
        step("post_trap_d", 3'd1, O_DEC);
        step("post_trap_e", 3'd2, O_EXE);
        step("post_trap_w", 3'd4, O_WB_RD);

        // mret with irq enabled at entry: both pulses together.
        irq   = 1'b0;
        instr = I_MRET;
        step("mret3_f", 3'd0, O_FRDY);
        step("mret3_d", 3'd1, O_DEC);
        step("mret3_e", 3'd2, O_EXE);
        step("mret3_w", 3'd4, O_WB_MRT);
        irq = 1'b1;
        step("mret4_f", 3'd0, O_FRDY);
        step("mret4_d", 3'd1, O_DEC);
        step("mret4_e", 3'd2, O_EXE);
        step("mret4_w", 3'd4, O_WB_MI);
        irq = 1'b0;
        check("mret_instret", instret, 32'd14);

        // Reset in the middle of a pending data request.
        instr = I_LOAD;
        step("rst_f", 3'd0, O_FRDY);
        step("rst_d", 3'd1, O_DEC);
        step("rst_e", 3'd2, O_EXE);
        bus.mem_ready = 1'b0;
        step("rst_m", 3'd3, O_LWAIT);
        reset = 1'b1;
        step("rst_hold", 3'd0, O_IDLE);
        reset = 1'b0;
        check("rst_instret", instret, 32'd0);
        step("rst_resume", 3'd0, O_FWAIT);
        bus.mem_ready = 1'b1;
        instr = I_ADDI;
        step("rst_addi_f", 3'd0, O_FRDY);
        step("rst_addi_d", 3'd1, O_DEC);
        step("rst_addi_e", 3'd2, O_EXE);
        step("rst_addi_w", 3'd4, O_WB_RD);
        check("rst_addi_instret", instret, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
